sdram_wb_master: RTL and testbench
==================================

SDRAM_WB_MASTER -- requirements
Module: sdram_wb_master

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles in S_STB without sdram_ack before abort.
REQ-002 Parameter LEN_W, default 8: width of burst length field.
REQ-003 CLK  input  1  sole clock; all logic on posedge CLK.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command request; accepted when cmd_ready=1.
REQ-006 cmd_ready  output  1  high only in S_IDLE.
REQ-007 cmd_we  input  1  1=write burst, 0=read burst.
REQ-008 cmd_addr  input  32  word address of first transfer.
REQ-009 cmd_len  input  LEN_W  number of words minus 1 (0 means 1 word).
REQ-010 wr_data  input  32  write word for current transfer.
REQ-011 wr_valid  input  1  wr_data valid.
REQ-012 wr_ready  output  1  one-cycle pulse when wr_data is consumed.
REQ-013 rd_data  output  32  last read word.
REQ-014 rd_valid  output  1  one-cycle pulse with each new rd_data.
REQ-015 done  output  1  one-cycle pulse when a burst completes.
REQ-016 err  output  1  one-cycle pulse on timeout abort.
REQ-017 cyc_i, stb_i, we_i  output  1 each  Wishbone cycle, strobe, write enable toward SDRAM.
REQ-018 sel_i  output  4  byte select, constant 4'b1111 while stb_i=1, else 4'b0000.
REQ-019 addr_i, data_i  output  32 each  Wishbone address and write data.
REQ-020 data_o  input  32  read data from SDRAM, valid while sdram_ack=1.
REQ-021 stall_o, sdram_ack  input  1 each  Wishbone stall and acknowledge (ack is level, held until cyc_i drops).

Function
REQ-022 States: S_IDLE, S_WDAT, S_CYC, S_STB, S_GAP, S_DONE.
REQ-023 S_IDLE: cmd_valid=1 latches we/addr/len, word index=0; next S_WDAT if cmd_we=1 else S_CYC.
REQ-024 S_WDAT: wait wr_valid=1; then register wr_data into data_i, pulse wr_ready, next S_CYC.
REQ-025 S_CYC: cyc_i=1, stb_i=0 for exactly one cycle; addr_i=base+index, we_i=latched we; next S_STB.
REQ-026 S_STB: cyc_i=1, stb_i=1; addr_i/data_i/we_i held stable; stall_o=1 holds state without counting toward acceptance.
REQ-027 S_STB with sdram_ack=1: reads register data_o into rd_data and pulse rd_valid next cycle; next S_GAP.
REQ-028 S_GAP: cyc_i=0, stb_i=0 for exactly one cycle (slave must see cyc drop to release ack); if index==len next S_DONE, else index+1, next S_WDAT (write) or S_CYC (read).
REQ-029 S_DONE: done=1 one cycle; next S_IDLE.
REQ-030 Timeout counter clears on entry to S_STB, increments each S_STB cycle without ack (stall cycles included); reaching TIMEOUT -> cyc_i=0, stb_i=0, err pulse, next S_IDLE, no done.
REQ-031 Address arithmetic: 32-bit, base+index wraps modulo 2^32.
REQ-032 cmd_valid outside S_IDLE ignored; no queuing.
REQ-033 sdram_ack outside S_STB ignored.
REQ-034 Burst length cmd_len=2^LEN_W-1 yields 2^LEN_W transfers; index counter must not overflow before compare.
REQ-035 Minimum per-word latency: CYC(1)+STB(1+slave latency)+GAP(1).

Reset
REQ-036 rst_n=0 at any time, including mid-burst, forces S_IDLE immediately: cyc_i=0, stb_i=0, we_i=0, sel_i=0, addr_i=0, data_i=0, rd_data=0, rd_valid=0, wr_ready=0, done=0, err=0, cmd_ready=1 after release; counters cleared.

Verification
REQ-037 Read 1 word: cmd_addr=5, cmd_len=0, slave mem[5]=32'hDEADBEEF, ack 5 cycles after stb -> one rd_valid with rd_data=32'hDEADBEEF, cyc_i drops, done one cycle later.
REQ-038 Write burst: cmd_we=1, cmd_addr=10, cmd_len=2, wr_data 1,2,3 -> slave mem[10..12]=1,2,3, three wr_ready pulses, cyc_i low one cycle between words, one done.
REQ-039 Stall: stall_o=1 for 3 cycles during S_STB -> addr_i/data_i stable throughout, transfer completes after ack, no err.
REQ-040 Timeout: slave never acks, TIMEOUT=64 -> err pulse 64 cycles after stb_i rises, cyc_i=0, no done, cmd_ready=1.
REQ-041 Reset mid-burst: rst_n low during word 2 of 4-word read -> all outputs at reset values same cycle; new read of addr 0 afterwards completes normally.
REQ-042 Busy command: cmd_valid pulsed with different addr during a burst -> ignored, original burst addresses unaffected.

Source files
------------

// File: rtl/sdram_wb_master_if.sv
// Command, write/read data and Wishbone master bus bundle for sdram_wb_master.
// Latency: none (wires only).
// Backpressure: carried by cmd_ready, wr_valid/wr_ready and stall_o/sdram_ack.
interface sdram_wb_master_if #(
    parameter int LEN_W = 8
);
    // command side
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    // write data stream
    logic [31:0]      wr_data;
    logic             wr_valid;
    logic             wr_ready;
    // read data and status
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             done;
    logic             err;
    // Wishbone toward SDRAM controller
    logic             cyc_i;
    logic             stb_i;
    logic             we_i;
    logic [3:0]       sel_i;
    logic [31:0]      addr_i;
    logic [31:0]      data_i;
    logic [31:0]      data_o;
    logic             stall_o;
    logic             sdram_ack;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_data, wr_valid,
               data_o, stall_o, sdram_ack,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, err,
               cyc_i, stb_i, we_i, sel_i, addr_i, data_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_data, wr_valid,
               data_o, stall_o, sdram_ack,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, err,
               cyc_i, stb_i, we_i, sel_i, addr_i, data_i
    );
endinterface

// File: rtl/sdram_wb_master.sv
// Burst Wishbone master: one CYC/STB/GAP transaction per word, done/err pulse per burst.
// Latency: per word CYC(1) + STB(1 + slave latency) + GAP(1), plus one WDAT cycle per write word.
// Backpressure: cmd_ready only in idle; waits on wr_valid; holds strobe under stall_o; aborts after TIMEOUT strobe cycles.
module sdram_wb_master #(
    parameter int TIMEOUT = 64,
    parameter int LEN_W   = 8
) (
    input  logic               CLK,
    input  logic               rst_n,
    sdram_wb_master_if.master  bus
);
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDAT,
        S_CYC,
        S_STB,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      base_q, base_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wr_take;

    // State register and datapath flops; reset returns everything to idle at once.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            base_q     <= 32'h0;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= 32'h0;
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state and datapath update; pulses default low and hold registers otherwise.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        tmo_d      = tmo_q;
        wr_take    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    we_d    = bus.cmd_we;
                    base_d  = bus.cmd_addr;
                    len_d   = bus.cmd_len;
                    idx_d   = '0;
                    state_d = bus.cmd_we ? S_WDAT : S_CYC;
                end
            end
            S_WDAT: begin
                if (bus.wr_valid) begin
                    data_d  = bus.wr_data;
                    wr_take = 1'b1;
                    state_d = S_CYC;
                end
            end
            S_CYC: begin
                // counter restarts for every strobe phase
                tmo_d   = '0;
                state_d = S_STB;
            end
            S_STB: begin
                // ack wins over stall: a level ack means the word has completed
                if (bus.sdram_ack) begin
                    if (!we_q) begin
                        rd_data_d  = bus.data_o;
                        rd_valid_d = 1'b1;
                    end
                    state_d = S_GAP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                // compare before increment so a full-range length never wraps early
                if (idx_q == len_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = we_q ? S_WDAT : S_CYC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from state; address wraps naturally in 32 bits.
    assign bus.cyc_i     = (state_q == S_CYC) || (state_q == S_STB);
    assign bus.stb_i     = (state_q == S_STB);
    assign bus.we_i      = we_q && bus.cyc_i;
    assign bus.sel_i     = (state_q == S_STB) ? 4'hF : 4'h0;
    assign bus.addr_i    = base_q + 32'(idx_q);
    assign bus.data_i    = data_q;
    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.wr_ready  = wr_take;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_sdram_wb_master.sv
`timescale 1ns/1ps
module tb_sdram_wb_master;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_wb_master_if #(.LEN_W(LEN_W)) bus ();

    sdram_wb_master #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
        .CLK   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model memory and reference memory ----------------
    logic [31:0] smem    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // ---------------- Wishbone slave ----------------
    int          s_cnt   = 0;
    int          s_stall = 0;
    int          s_lat   = 0;
    bit          s_noack = 1'b0;
    logic [31:0] s_addr, s_data;
    logic [32:0] bus_log[$];

    initial begin
        bus.sdram_ack = 1'b0;
        bus.stall_o   = 1'b0;
        bus.data_o    = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!bus.cyc_i) begin
                bus.sdram_ack = 1'b0;
                bus.stall_o   = 1'b0;
                s_cnt         = 0;
            end else if (bus.stb_i && !bus.sdram_ack) begin
                s_cnt++;
                if (s_cnt == 1) begin
                    s_addr = bus.addr_i;
                    s_data = bus.data_i;
                    chk("sel_during_stb", 64'(bus.sel_i), 64'h0F);
                end else begin
                    chk("stb_addr_stable", 64'(bus.addr_i), 64'(s_addr));
                    chk("stb_data_stable", 64'(bus.data_i), 64'(s_data));
                end
                bus.stall_o = (s_cnt <= s_stall);
                if (!s_noack && s_cnt > s_stall + s_lat) begin
                    bus.sdram_ack = 1'b1;
                    bus.stall_o   = 1'b0;
                    bus_log.push_back({bus.we_i, bus.addr_i});
                    if (bus.we_i) smem[bus.addr_i] = bus.data_i;
                    else bus.data_o = smem.exists(bus.addr_i) ? smem[bus.addr_i] : dflt(bus.addr_i);
                end
            end
        end
    end

    // ---------------- write data source ----------------
    logic [31:0] wr_q[$];
    int          n_wrrdy = 0;
    bit          wr_pend = 1'b0;

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (wr_pend) begin
                void'(wr_q.pop_front());
                wr_pend = 1'b0;
            end
            bus.wr_valid = (wr_q.size() > 0) && ($urandom_range(0, 3) != 0);
            bus.wr_data  = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
            #1;
            if (bus.wr_valid && bus.wr_ready) begin
                wr_pend = 1'b1;
                n_wrrdy++;
            end
        end
    end

    // ---------------- output monitor ----------------
    int          cyc_n = 0, n_done = 0, n_err = 0, n_falls = 0;
    int          stb_rise_at = 0, err_at = 0, low_run = 0, max_gap = 0;
    bit          prev_cyc = 1'b0, prev_stb = 1'b0;
    logic [31:0] rd_got[$];

    initial begin
        forever begin
            @(posedge clk); #3;
            cyc_n++;
            if (bus.rd_valid) rd_got.push_back(bus.rd_data);
            if (bus.done) n_done++;
            if (bus.err) begin
                n_err++;
                err_at = cyc_n;
            end
            if (bus.stb_i && !prev_stb) stb_rise_at = cyc_n;
            if (prev_cyc && !bus.cyc_i) n_falls++;
            if (bus.cyc_i) begin
                if (!prev_cyc && low_run > max_gap) max_gap = low_run;
                low_run = 0;
            end else if (!bus.cmd_ready && !bus.done) begin
                low_run++;
            end else begin
                low_run = 0;
            end
            prev_cyc = bus.cyc_i;
            prev_stb = bus.stb_i;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_cmd(input bit we, input logic [31:0] addr, input int len);
        int i;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LEN_W'(len);
        i = 0;
        while (!bus.cmd_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("cmd_accept", 64'(bus.cmd_ready), 64'h1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int d0;
        int i;
        d0 = n_done + n_err;
        i  = 0;
        while (n_done + n_err == d0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) chk("end_budget", 64'h0, 64'h1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cyc"},      64'(bus.cyc_i),    64'h0);
        chk({tag, "_stb"},      64'(bus.stb_i),    64'h0);
        chk({tag, "_we"},       64'(bus.we_i),     64'h0);
        chk({tag, "_sel"},      64'(bus.sel_i),    64'h0);
        chk({tag, "_addr"},     64'(bus.addr_i),   64'h0);
        chk({tag, "_data_i"},   64'(bus.data_i),   64'h0);
        chk({tag, "_rd_data"},  64'(bus.rd_data),  64'h0);
        chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'h0);
        chk({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'h0);
        chk({tag, "_done"},     64'(bus.done),     64'h0);
        chk({tag, "_err"},      64'(bus.err),      64'h0);
    endtask

    // One burst checked against the reference: expected data, address sequence,
    // handshake counts and memory contents all come from the burst description.
    task automatic run_cmd(input bit we, input logic [31:0] addr, input int len,
                           input bit seq_data, input bit poke_busy, input string tag);
        logic [31:0] exp_rd[$];
        logic [32:0] exp_log[$];
        logic [31:0] a, w;
        int d0, e0, w0, f0, budget;
        rd_got.delete();
        bus_log.delete();
        max_gap = 0;
        d0 = n_done; e0 = n_err; w0 = n_wrrdy; f0 = n_falls;
        for (int i = 0; i <= len; i++) begin
            a = addr + 32'(i);
            if (we) begin
                w = seq_data ? 32'(i + 1) : $urandom;
                wr_q.push_back(w);
                ref_mem[a] = w;
            end else begin
                exp_rd.push_back(ref_rd(a));
            end
            exp_log.push_back({we, a});
        end
        start_cmd(we, addr, len);
        if (poke_busy) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            bus.cmd_we    = ~we;
            bus.cmd_addr  = addr + 32'h1000;
            bus.cmd_len   = '0;
            repeat (3) @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
        budget = (len + 1) * (s_stall + s_lat + 20) + 50;
        wait_end(budget);
        chk({tag, "_done"},  64'(n_done - d0),  64'h1);
        chk({tag, "_noerr"}, 64'(n_err - e0),   64'h0);
        chk({tag, "_falls"}, 64'(n_falls - f0), 64'(len + 1));
        chk({tag, "_nrd"},   64'(rd_got.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_got.size(); i++)
            chk({tag, "_rd_data"}, 64'(rd_got[i]), 64'(exp_rd[i]));
        chk({tag, "_nxfer"}, 64'(bus_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
            chk({tag, "_xfer_addr"}, 64'(bus_log[i]), 64'(exp_log[i]));
        if (we) begin
            chk({tag, "_wr_ready"}, 64'(n_wrrdy - w0), 64'(len + 1));
            for (int i = 0; i <= len; i++) begin
                a = addr + 32'(i);
                chk({tag, "_mem"}, smem.exists(a) ? 64'(smem[a]) : 64'hBAD, 64'(ref_mem[a]));
            end
        end else if (len > 0) begin
            chk({tag, "_gap"}, 64'(max_gap), 64'h1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int e0, d0, i;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_len   = '0;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'h1);

        // single-word read, slave answers five cycles after the strobe
        smem[32'd5]    = 32'hDEADBEEF;
        ref_mem[32'd5] = 32'hDEADBEEF;
        s_stall = 0; s_lat = 5;
        run_cmd(1'b0, 32'd5, 0, 1'b0, 1'b0, "rd1");

        // three-word write of 1,2,3
        s_lat = 1;
        run_cmd(1'b1, 32'd10, 2, 1'b1, 1'b0, "wr3");

        // stalled strobes on a write and a read
        s_stall = 3; s_lat = 1;
        run_cmd(1'b1, 32'h300, 0, 1'b0, 1'b0, "stall_wr");
        run_cmd(1'b0, 32'h300, 1, 1'b0, 1'b0, "stall_rd");
        s_stall = 0;

        // command presented while busy must be ignored
        run_cmd(1'b0, 32'd200, 2, 1'b0, 1'b1, "busy");

        // slave never acknowledges
        s_noack = 1'b1;
        e0 = n_err; d0 = n_done;
        start_cmd(1'b0, 32'h40, 0);
        wait_end(200);
        chk("tmo_err",       64'(n_err - e0),            64'h1);
        chk("tmo_latency",   64'(err_at - stb_rise_at),  64'(TIMEOUT));
        chk("tmo_no_done",   64'(n_done - d0),           64'h0);
        chk("tmo_cyc",       64'(bus.cyc_i),             64'h0);
        chk("tmo_cmd_ready", 64'(bus.cmd_ready),         64'h1);
        s_noack = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset during the second word of a four-word read
        s_lat = 2;
        bus_log.delete();
        start_cmd(1'b0, 32'd100, 3);
        i = 0;
        while (!(bus_log.size() == 1 && bus.stb_i) && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("midrst_reach_word2", 64'(bus_log.size() == 1 && bus.stb_i), 64'h1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
        run_cmd(1'b0, 32'd0, 0, 1'b0, 1'b0, "post_rst");

        // randomized bursts, including addresses that wrap past 2^32
        for (int k = 0; k < 25; k++) begin
            logic [31:0] ad;
            bit          we;
            ad      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            we      = 1'($urandom_range(0, 1));
            s_stall = $urandom_range(0, 3);
            s_lat   = $urandom_range(0, 4);
            run_cmd(we, ad, $urandom_range(0, 6), 1'b0, 1'b0, "rand");
        end

        // full-length burst across the address wrap
        s_stall = 0; s_lat = 0;
        run_cmd(1'b0, 32'hFFFF_FF80, (1 << LEN_W) - 1, 1'b0, 1'b0, "maxlen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
